gpr_wb_arbiter: RTL
===================

Name: gpr_wb_arbiter

Overview:
- Single owner of the integer register file write port (wen0/waddr0/wd0).
- Arbitrates writebacks from three requesters: ALU result, CSR read data, FPU integer result (e.g. fmv.x.w, compares).
- Each requester gets a one-entry holding buffer, so collisions stall only the losing source.
- Enforces same-rd write ordering and exposes rd-pending status so decode can interlock rs1/rs2 reads.

Parameters:
- STARVE_LIMIT, 4, cycles a buffered entry may lose arbitration before it is forced to top priority.
- CNT_W, 3, starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst_l  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous; discards all buffered entries
- alu_valid / csr_valid / fpu_valid  in  1 each  source has writeback
- alu_rd / csr_rd / fpu_rd  in  5 each  destination register
- alu_data / csr_data / fpu_data  in  32 each  write data
- alu_ready / csr_ready / fpu_ready  out  1 each  source accepted this cycle
- gpr_wen  out  1  register file write enable
- gpr_waddr  out  5  write address
- gpr_wdata  out  32  write data
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_busy, rs2_busy  out  1 each  read address has a pending write
- pend_mask  out  32  bit i set when any buffer holds rd==i; bit 0 always 0

Behaviour:
- Reset (rst_l low, asynchronous):
  - All buffers invalid, starvation counters 0, age matrix cleared.
  - All outputs 0, including readys.
- Handshake:
  - A source transfers on valid & ready.
  - ready = ~buf_valid | buf_granted (combinational), so a granted buffer can refill in the same cycle.
  - While ready is low, the source must hold valid, rd and data stable.
- rd == 0: the handshake is accepted but the buffer is not loaded (write silently dropped), so ready is unaffected.
- Capture: an accept at edge N sets buf_valid, rd and data. The entry is eligible in cycle N+1.
- Write port:
  - gpr_wen / gpr_waddr / gpr_wdata are combinational from the granted buffer.
  - Minimum latency accept→write is 1 cycle.
  - When nothing is granted, gpr_wen = 0 and address/data = 0.
- Eligibility: a buffer is eligible if valid and no older valid buffer holds the same rd.
  - Age is tracked with a 3x3 age matrix, updated on each load.
  - Simultaneous loads in the same cycle are ordered CSR older than FPU older than ALU.
- Grant:
  - If any eligible buffer has counter >= STARVE_LIMIT, grant the starved one; ties break by age (oldest first).
  - Otherwise use fixed priority among eligible buffers: CSR > FPU > ALU.
  - Exactly one grant per cycle. The granted buffer clears at the edge unless it reloads.
- Starvation counter: increments (saturating) each cycle its buffer is valid and not granted; resets to 0 on grant or load.
- Busy:
  - rsX_busy = (rsX_addr != 0) & any valid buffer with rd == rsX_addr.
  - Combinational; the entry being granted this cycle still counts as busy.
- Flush:
  - At the edge, all buffers are invalidated, counters zeroed, and new accepts are ignored.
  - gpr_wen is forced 0 in the flush cycle.
  - Readys are 0 during flush.
- Reset mid-operation: buffered data is lost and no partial write is issued.

Decomposition:
- Shared package gpr_wb_pkg holds:
  - source index constants SRC_CSR=0, SRC_FPU=1, SRC_ALU=2 and NUM_SRC=3;
  - the typedef for a buffer entry {valid, rd[4:0], data[31:0]}.
- One sub-module, wb_src_buffer, instantiated three times. It holds:
  - the entry register;
  - the starvation counter;
  - ready generation.
- Age matrix, grant logic and busy compare stay in the top level.

Test Plan:
- Single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle → gpr_wen=1, waddr=5, wdata=0xDEADBEEF in the next cycle; alu_ready stays 1.
- Three-way collision: all sources valid in the same cycle with rd=1/2/3 → writes in consecutive cycles in order CSR(1), FPU(2), ALU(3); no source loses data.
- Same-rd ordering: ALU rd=7 accepted at cycle 0, then CSR rd=7 at cycle 1 while the ALU entry is blocked by an earlier CSR stream → ALU value written before CSR value; final x7 = CSR data.
- Starvation: CSR and FPU valid continuously with distinct rds, ALU entry buffered → ALU write issues no later than STARVE_LIMIT+1 = 5 cycles after capture.
- rd=0 and busy: FPU rd=0 accepted → no gpr_wen. ALU rd=9 buffered, rs1_addr=9 → rs1_busy=1 until the write cycle completes; rs2_addr=0 → rs2_busy=0.
- Flush and reset: three entries buffered, flush=1 → gpr_wen=0 that cycle and thereafter, pend_mask=0. Asserting rst_l=0 mid-stream clears all outputs immediately (asynchronously).

Source files
------------

// File: rtl/gpr_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_pkg
// Description : Shared types and constants for the GPR writeback arbiter.
//               Source indices double as the simultaneous-load age order and
//               the fixed grant priority: CSR, then FPU, then ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package gpr_wb_pkg;

    localparam int NUM_SRC = 3;
    localparam int SRC_CSR = 0;
    localparam int SRC_FPU = 1;
    localparam int SRC_ALU = 2;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    // One holding-buffer entry
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // One-hot decode of a register index into a 32-bit mask
    function automatic logic [31:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [31:0] mask;
        mask     = '0;
        mask[rd] = 1'b1;
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_wb_arbiter_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_src_buffer
// Description : One-entry holding buffer for a single writeback source.
//               Holds the pending entry, its starvation counter, and drives
//               the source ready. A granted entry may be replaced in the same
//               cycle, so a source that wins every cycle never stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_src_buffer
    import gpr_wb_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              flush,
    input  logic              src_valid,
    input  logic [REG_AW-1:0] src_rd,
    input  logic [XLEN-1:0]   src_data,
    input  logic              granted,
    output logic              src_ready,
    output logic              load,
    output wb_entry_t         entry,
    output logic [CNT_W-1:0]  starve_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    wb_entry_t        r_entry;
    logic [CNT_W-1:0] r_cnt;

    // Ready is held low during reset and flush so nothing is accepted then
    assign src_ready  = rst_l & ~flush & (~r_entry.valid | granted);

    // Writes to x0 complete the handshake but never occupy the buffer
    assign load       = src_valid & src_ready & (src_rd != '0);

    assign entry      = r_entry;
    assign starve_cnt = r_cnt;

    // Entry register and saturating count of lost arbitration cycles
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_entry <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_entry <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_entry <= {1'b1, src_rd, src_data};
            r_cnt   <= '0;
        end else if (granted) begin
            r_entry.valid <= 1'b0;
            r_cnt         <= '0;
        end else if (r_entry.valid && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arbiter
// Description : Sole owner of the integer register-file write port. Buffers
//               ALU, CSR and FPU writebacks, keeps same-rd writes in arrival
//               order via an age matrix, grants one buffer per cycle (starved
//               entries first, else CSR > FPU > ALU) and reports pending rds
//               so decode can interlock operand reads.
//               STARVE_LIMIT must be representable in CNT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              csr_valid,
    input  logic [REG_AW-1:0] csr_rd,
    input  logic [XLEN-1:0]   csr_data,
    output logic              csr_ready,
    input  logic              fpu_valid,
    input  logic [REG_AW-1:0] fpu_rd,
    input  logic [XLEN-1:0]   fpu_data,
    output logic              fpu_ready,
    output logic              gpr_wen,
    output logic [REG_AW-1:0] gpr_waddr,
    output logic [XLEN-1:0]   gpr_wdata,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [31:0]       pend_mask
);

    localparam logic [CNT_W-1:0] c_starve_thr = CNT_W'(STARVE_LIMIT);

    logic [NUM_SRC-1:0] w_src_valid;
    logic [REG_AW-1:0]  w_src_rd    [NUM_SRC];
    logic [XLEN-1:0]    w_src_data  [NUM_SRC];
    logic [NUM_SRC-1:0] w_src_ready;
    logic [NUM_SRC-1:0] w_load;
    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_starved;
    wb_entry_t          w_entry     [NUM_SRC];
    logic [CNT_W-1:0]   w_starve_cnt[NUM_SRC];

    // r_older[i][j] set means buffer i was loaded before buffer j
    logic [NUM_SRC-1:0] r_older     [NUM_SRC];

    assign w_src_valid[SRC_CSR] = csr_valid;
    assign w_src_valid[SRC_FPU] = fpu_valid;
    assign w_src_valid[SRC_ALU] = alu_valid;
    assign w_src_rd[SRC_CSR]    = csr_rd;
    assign w_src_rd[SRC_FPU]    = fpu_rd;
    assign w_src_rd[SRC_ALU]    = alu_rd;
    assign w_src_data[SRC_CSR]  = csr_data;
    assign w_src_data[SRC_FPU]  = fpu_data;
    assign w_src_data[SRC_ALU]  = alu_data;

    assign csr_ready = w_src_ready[SRC_CSR];
    assign fpu_ready = w_src_ready[SRC_FPU];
    assign alu_ready = w_src_ready[SRC_ALU];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_buf
        wb_src_buffer #(
            .CNT_W      (CNT_W)
        ) u_buf (
            .clk        (clk),
            .rst_l      (rst_l),
            .flush      (flush),
            .src_valid  (w_src_valid[gi]),
            .src_rd     (w_src_rd[gi]),
            .src_data   (w_src_data[gi]),
            .granted    (w_grant[gi]),
            .src_ready  (w_src_ready[gi]),
            .load       (w_load[gi]),
            .entry      (w_entry[gi]),
            .starve_cnt (w_starve_cnt[gi])
        );
    end

    // Age matrix: a loading buffer becomes younger than every resident entry;
    // buffers loading together are ordered by source index
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int j = 0; j < NUM_SRC; j++) begin
                    if (i != j) begin
                        if (w_load[i] && w_load[j]) begin
                            r_older[i][j] <= (i < j);
                        end else if (w_load[i]) begin
                            r_older[i][j] <= 1'b0;
                        end else if (w_load[j]) begin
                            r_older[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Eligibility: valid and no older resident entry targets the same rd
    always_comb begin
        w_elig    = '0;
        w_starved = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_elig[i] = w_entry[i].valid;
            for (int j = 0; j < NUM_SRC; j++) begin
                if ((j != i) && w_entry[j].valid && r_older[j][i] &&
                    (w_entry[j].rd == w_entry[i].rd)) begin
                    w_elig[i] = 1'b0;
                end
            end
            w_starved[i] = w_elig[i] && (w_starve_cnt[i] >= c_starve_thr);
        end
    end

    // Grant: oldest starved entry wins, else fixed priority by source index
    always_comb begin
        logic found;
        logic oldest;
        w_grant = '0;
        found   = 1'b0;
        oldest  = 1'b0;
        if (!flush) begin
            if (|w_starved) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    oldest = w_starved[i];
                    for (int j = 0; j < NUM_SRC; j++) begin
                        if ((j != i) && w_starved[j] && r_older[j][i]) begin
                            oldest = 1'b0;
                        end
                    end
                    if (oldest) begin
                        w_grant[i] = 1'b1;
                    end
                end
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (w_elig[i] && !found) begin
                        w_grant[i] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    end

    // Register-file write port driven straight from the granted buffer
    always_comb begin
        gpr_wen   = |w_grant;
        gpr_waddr = '0;
        gpr_wdata = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                gpr_waddr = gpr_waddr | w_entry[i].rd;
                gpr_wdata = gpr_wdata | w_entry[i].data;
            end
        end
    end

    // Pending-rd mask and operand interlock; a granted entry still counts
    always_comb begin
        pend_mask = '0;
        rs1_busy  = 1'b0;
        rs2_busy  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_entry[i].valid) begin
                pend_mask = pend_mask | rd_onehot(w_entry[i].rd);
                if (w_entry[i].rd == rs1_addr) begin
                    rs1_busy = 1'b1;
                end
                if (w_entry[i].rd == rs2_addr) begin
                    rs2_busy = 1'b1;
                end
            end
        end
        pend_mask[0] = 1'b0;
        rs1_busy     = rs1_busy & (rs1_addr != '0);
        rs2_busy     = rs2_busy & (rs2_addr != '0);
    end

endmodule
`default_nettype wire
